ic_bd_transpose_pingpong: RTL and testbench
===========================================

Name: ic_bd_transpose_pingpong

Overview:
Parametrised N x N transpose buffer for the 2-D BinDCT datapath, placed between the row-pass and column-pass 1-D transforms. Two ping-pong banks let one block be written as rows while the previous block is read out as columns, sustaining one row per cycle. Valid/ready handshakes on both sides replace the single-buffer writerequest/readrequest scheme. A per-block mode selects transpose or straight pass-through.

Parameters:
N, 8, block dimension (rows = columns = elements per word); N >= 2
W, 12, element width in bits (two's complement, not interpreted)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid row
in_ready  output  1  block can accept a row this cycle
in_data  input  N*W  row; element 0 in the MSBs [N*W-1 -: W]
in_bypass  input  1  sampled with row 0 of a block; 1 = no transpose for that block
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  N*W  output word; element 0 in the MSBs
bank_full  output  2  per-bank full flag, bit b = bank b
busy  output  1  any bank full or out_valid high

Behaviour:
- Storage: two banks, each N*N elements of W bits; memory contents are not reset.
- Write side: wr_bank (1 bit) and wr_row (clog2 N) counters. in_ready = ~bank_full[wr_bank].
- Write transfer = in_valid & in_ready. Element j of the row goes to bank[wr_bank][r=wr_row][c=j].
- On a transfer with wr_row==0, in_bypass is latched into bypass[wr_bank].
- On a transfer with wr_row==N-1: wr_row wraps to 0, bank_full[wr_bank] is set next cycle, and wr_bank toggles.
- Read side: rd_bank and rd_idx (clog2 N) counters, plus registered out_data/out_valid.
- Load condition: bank_full[rd_bank] & (~out_valid | out_ready).
- On load:
  - Transpose mode (bypass=0): out_data element i = bank[rd_bank][r=i][c=rd_idx], i.e. out word k = {row0[k], row1[k], ..., rowN-1[k]}.
  - Bypass mode: out_data = stored row rd_idx unchanged.
  - out_valid is set.
- Read index: rd_idx increments on each load. On the load with rd_idx==N-1, rd_idx wraps to 0, bank_full[rd_bank] is cleared next cycle, and rd_bank toggles.
- Output is FIFO order per block (word 0 first); blocks leave in arrival order.
- When out_valid & out_ready and the load condition is false, out_valid clears next cycle.
- out_data is held stable while out_valid & ~out_ready.
- Latency:
  - Last row of a block written at cycle t → bank_full set at t+1 → first out_valid at t+2.
  - Throughput is one word per cycle with out_ready held high.
- Simultaneous events:
  - The write of the last row into one bank and the read of the last word of the other bank in the same cycle are both honoured; both flags update independently.
  - A bank that becomes full while the other is draining is read immediately after, with no bubble.
- Full: both banks full → in_ready=0; rows with in_valid are ignored (no overwrite).
- Empty: no full bank → no load; out_valid drops once the held word is accepted.
- Reset (any cycle, including mid-block): wr_bank, rd_bank, wr_row, rd_idx, bank_full, bypass, out_valid ← 0; out_data ← 0; busy ← 0; in_ready=1 the cycle after reset deasserts. A partial block is discarded.

Optional Feature:
Macro TM_BLOCK_MARKERS_EN.
- Defined: adds output ports out_first (1) and out_last (1), registered with out_data.
  - out_first=1 on the word loaded with rd_idx==0; out_last=1 on the word loaded with rd_idx==N-1.
  - Both hold while the word is stalled and reset to 0.
- Not defined: ports and logic absent; downstream counts words itself.

Test Plan:
- N=8,W=12, rows r with element c = 16*r+c, out_ready=1, bypass=0 → 8 words, word k element i = 16*i+k; first out_valid 2 cycles after row 7 accepted.
- Same data with in_bypass=1 on row 0 → output words equal input rows 0..7 in order, unchanged.
- Three back-to-back blocks, out_ready=0 → in_ready drops after row 7 of block 2 (bank_full=2'b11), stays 0. Release out_ready → block 1 then block 2 emerge intact, in_ready returns after block 1's last word.
- Random out_ready (50%) with continuous input → out_data stable during every stall; no word lost or duplicated across 10 blocks vs. reference model.
- Assert reset after row 4 of block 0 and again while out_valid=1 mid-block → all outputs 0 next cycle, bank_full=0, in_ready=1; the following full block transposes correctly.
- TM_BLOCK_MARKERS_EN defined, two blocks → out_first high on words 0 and 8 only, out_last on words 7 and 15 only, held under stall.

Source files
------------

// File: rtl/ic_bd_transpose_pingpong_if.sv
// ic_bd_transpose_pingpong_if: row-in / word-out handshake bundle for the transpose buffer (TM_BLOCK_MARKERS_EN adds block markers)
interface ic_bd_transpose_pingpong_if #(parameter int N = 8, parameter int W = 12);
  logic in_valid;
  logic in_ready;
  logic [N*W-1:0] in_data;
  logic in_bypass;
  logic out_valid;
  logic out_ready;
  logic [N*W-1:0] out_data;
  logic [1:0] bank_full;
  logic busy;
`ifdef TM_BLOCK_MARKERS_EN
  logic out_first;
  logic out_last;
`endif
  modport slave (
    input in_valid, in_data, in_bypass, out_ready,
`ifdef TM_BLOCK_MARKERS_EN
    output out_first, out_last,
`endif
    output in_ready, out_valid, out_data, bank_full, busy
  );
  modport master (
    output in_valid, in_data, in_bypass, out_ready,
`ifdef TM_BLOCK_MARKERS_EN
    input out_first, out_last,
`endif
    input in_ready, out_valid, out_data, bank_full, busy
  );
endinterface

// File: rtl/ic_bd_transpose_pingpong.sv
// ic_bd_transpose_pingpong: ping-pong N x N transpose/bypass buffer between BinDCT passes (TM_BLOCK_MARKERS_EN adds out_first/out_last)
module ic_bd_transpose_pingpong #(
  parameter int N = 8,
  parameter int W = 12
) (
  input logic clk,
  input logic reset,
  ic_bd_transpose_pingpong_if.slave bus
);
  localparam int AW = $clog2(N);
  logic [W-1:0] mem [2][N][N];
  logic wr_bank, rd_bank;
  logic [AW-1:0] wr_row, rd_idx;
  logic [1:0] bank_full, bypass;
  logic out_valid;
  logic [N*W-1:0] out_data, nxt;
  logic wr_fire, wr_last, load, rd_last;
  assign wr_fire = bus.in_valid & ~bank_full[wr_bank];
  assign wr_last = wr_fire & (wr_row == AW'(N-1));
  assign load = bank_full[rd_bank] & (~out_valid | bus.out_ready);
  assign rd_last = load & (rd_idx == AW'(N-1));
  assign bus.in_ready = ~bank_full[wr_bank];
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.bank_full = bank_full;
  assign bus.busy = |bank_full | out_valid;
  // next output word: column rd_idx of the read bank, or row rd_idx when the block bypasses
  always_comb begin
    nxt = '0;
    for (int i = 0; i < N; i++)
      nxt[(N-1-i)*W +: W] = bypass[rd_bank] ? mem[rd_bank][rd_idx][i] : mem[rd_bank][i][rd_idx];
  end
  // row write into the current write bank; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_fire)
      for (int j = 0; j < N; j++)
        mem[wr_bank][wr_row][j] <= bus.in_data[(N-1-j)*W +: W];
  end
  // write/read counters, bank ownership flags and the registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row <= '0;
      rd_idx <= '0;
      bank_full <= '0;
      bypass <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row == '0) bypass[wr_bank] <= bus.in_bypass;
        wr_row <= wr_last ? '0 : wr_row + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (load) begin
        out_data <= nxt;
        out_valid <= 1'b1;
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
      bank_full <= (bank_full | (2'(wr_last) << wr_bank)) & ~(2'(rd_last) << rd_bank);
    end
  end
`ifdef TM_BLOCK_MARKERS_EN
  logic out_first, out_last;
  assign bus.out_first = out_first;
  assign bus.out_last = out_last;
  // block boundary markers travel with the loaded word and hold while it stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else if (load) begin
      out_first <= rd_idx == '0;
      out_last <= rd_idx == AW'(N-1);
    end
  end
`endif
endmodule

// File: tb/tb_ic_bd_transpose_pingpong.sv
// tb_ic_bd_transpose_pingpong: directed and random checks of the transpose buffer against a block-level model
module tb_ic_bd_transpose_pingpong;
  localparam int N = 8;
  localparam int W = 12;
  localparam int DW = N*W;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  ic_bd_transpose_pingpong_if #(.N(N), .W(W)) bus ();
  ic_bd_transpose_pingpong #(.N(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rows[N];
  int row_cnt = 0;
  logic blk_byp = 1'b0;
  int out_cnt = 0;
  bit rnd_ready = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] pat_row(input int r);
    logic [DW-1:0] d;
    for (int c = 0; c < N; c++) d[(N-1-c)*W +: W] = W'(16*r + c);
    return d;
  endfunction
  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] d;
    for (int c = 0; c < N; c++) d[(N-1-c)*W +: W] = W'($urandom);
    return d;
  endfunction
  task automatic push_block();
    logic [DW-1:0] w;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) w[(N-1-i)*W +: W] = rows[i][(N-1-k)*W +: W];
      exp_q.push_back(blk_byp ? rows[k] : w);
    end
  endtask
  task automatic step();
    if (rnd_ready) bus.out_ready = 1'($urandom);
    if (bus.out_valid === 1'b1) begin
      chkb("spurious_word", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
`ifdef TM_BLOCK_MARKERS_EN
      chkb("out_first", bus.out_first, (out_cnt % N) == 0);
      chkb("out_last", bus.out_last, (out_cnt % N) == N-1);
`endif
    end
    if (reset) begin
      exp_q.delete();
      row_cnt = 0;
      out_cnt = 0;
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        out_cnt++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        if (row_cnt == 0) blk_byp = bus.in_bypass;
        rows[row_cnt] = bus.in_data;
        row_cnt++;
        if (row_cnt == N) begin
          push_block();
          row_cnt = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_row(input logic [DW-1:0] d, input logic byp);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_bypass = byp;
    for (int t = 0; t < 400 && !ok; t++) begin
      ok = bus.in_ready === 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) chkb("send_timeout", 1'b0, 1'b1);
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    for (int t = 0; t < 2000 && (exp_q.size() > 0 || bus.out_valid !== 1'b0); t++) step();
    chkb("drain_empty", exp_q.size() == 0, 1'b1);
    chkb("drain_out_valid", bus.out_valid, 1'b0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_bank_full", DW'(bus.bank_full), DW'(2'b00));
    chkb("rst_busy", bus.busy, 1'b0);
    chkb("rst_in_ready", bus.in_ready, 1'b1);
  endtask
  initial begin
    int base;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    // transpose of the pattern block, with latency check
    for (int r = 0; r < N; r++) send_row(pat_row(r), 1'b0);
    chk("lat_bank_full", DW'(bus.bank_full), DW'(2'b01));
    chkb("lat_no_valid_yet", bus.out_valid, 1'b0);
    step();
    chkb("lat_first_valid", bus.out_valid, 1'b1);
    drain();
    // bypass block
    for (int r = 0; r < N; r++) send_row(pat_row(r), r == 0);
    drain();
    // fill both banks with output stalled, then release
    bus.out_ready = 1'b0;
    for (int r = 0; r < 2*N; r++) send_row(pat_row(r + 3), 1'b0);
    chk("full_bank_full", DW'(bus.bank_full), DW'(2'b11));
    chkb("full_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = pat_row(40);
    for (int t = 0; t < 4; t++) begin
      chkb("full_blocked", bus.in_ready, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    base = out_cnt;
    for (int t = 0; t < N+2; t++) begin
      chkb("release_in_ready", bus.in_ready, (out_cnt - base) >= N-1);
      step();
    end
    drain();
    // random data, random bypass, random backpressure over 10 blocks
    rnd_ready = 1;
    base = out_cnt;
    for (int b = 0; b < 10; b++) begin
      logic byp;
      byp = 1'($urandom);
      for (int r = 0; r < N; r++) send_row(rnd_row(), byp);
    end
    drain();
    chkb("random_word_count", (out_cnt - base) == 10*N, 1'b1);
    rnd_ready = 0;
    bus.out_ready = 1'b1;
    // reset mid-block on the write side, then mid-block on the read side
    for (int r = 0; r < 5; r++) send_row(pat_row(r), 1'b0);
    do_reset();
    bus.out_ready = 1'b0;
    for (int r = 0; r < N; r++) send_row(pat_row(r + 1), 1'b0);
    step();
    step();
    chkb("stall_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) step();
    bus.out_ready = 1'b0;
    chkb("mid_valid", bus.out_valid, 1'b1);
    do_reset();
    bus.out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(pat_row(r + 5), 1'b0);
    drain();
    // two blocks under random stalls (exercises block markers when present)
    rnd_ready = 1;
    for (int r = 0; r < 2*N; r++) send_row(pat_row(r), 1'b0);
    drain();
    rnd_ready = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
